balik_uretici: RTL
==================

# balik_uretici

Stimulus-side companion of the `penguenler` hunt-statistics block. It generates the packed 15-bit per-cycle catch bus `avlanan_balik` for five penguins and keeps a per-penguin running total. Once a penguin has reached the target, its field is forced to zero. Generation stops when every penguin is done, when the consumer reports `bitti`, or on timeout. It sits directly upstream of `penguenler` on the same clock.

## Interface
- `HEDEF`, 28: per-penguin catch target; penguin *i* is done when its total is ≥ `HEDEF`.
- `ZAMAN_ASIMI`, 100: maximum URET cycles before forced stop; must be ≤ 127.
- `saat`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `basla`  in  1  start pulse; sampled in BOS or BITTI only.
- `mod`  in  2  pattern: 0 = constant, 1 = LFSR, 2 = ramp, 3 = treated as 0.
- `sabit`  in  3  constant value for mod 0.
- `tohum`  in  16  LFSR seed for mod 1; value 0 is replaced by 16'hACE1.
- `bitti_in`  in  1  `bitti` from `penguenler`; consumer finished.
- `avlanan_balik`  out  15  catch bus; field *i* (penguin *i*+1) = bits [3i+2:3i]; penguin 1 is the LSB field.
- `gecerli`  out  1  high while in URET.
- `tamam`  out  5  per-penguin done mask; bit *i* = penguin *i*+1.
- `uretim_bitti`  out  1  high in BITTI.
- `zaman_asimi`  out  1  set if BITTI was entered by timeout.
- `dongu_sayisi`  out  7  number of URET cycles in the current run.

## Operation
- **States:**
  - BOS (idle; entered on reset).
  - URET (generating).
  - BITTI (finished; outputs held, bus = 0).
- **Sampling `basla`:** `basla` is sampled in BOS or BITTI and ignored in URET.
- **On the `basla` edge:**
  - Clear all sums, `tamam`, `zaman_asimi` and `uretim_bitti`.
  - Set `dongu_sayisi` = 1.
  - Load the LFSR with `tohum`, or 16'hACE1 if `tohum` is 0.
  - Register the first bus value and enter URET.
- **Each later URET edge:**
  - If any stop condition holds, go to BITTI.
  - Otherwise load the next bus value and increment `dongu_sayisi`.
- **Stop conditions, in priority order:**
  1. All `tamam` set.
  2. `bitti_in` = 1.
  3. `dongu_sayisi` == `ZAMAN_ASIMI`.
  - `zaman_asimi` is set only when condition 3 is the sole cause.
- **Field value (raw) for penguin *i*:**
  - mod 0: `sabit`.
  - mod 1: L[3i+2:3i], where L is the LFSR value loaded on this edge (the seed on the `basla` edge, the next LFSR step thereafter).
  - mod 2: (`dongu_sayisi` − 1 + *i*) mod 8, using the count being loaded.
- **LFSR:** 16-bit Galois, right shift; next = {0, L[15:1]} ^ (L[0] ? 16'hB400 : 0). It advances only on URET loads.
- **Masking:** a field is 0 if its `tamam` bit is already set; otherwise it carries the raw value.
- **Accumulation:** on the same edge as the load, sum_i += loaded field (7-bit sum, no overflow for `HEDEF` ≤ 120). `tamam`[i] is set on that edge if the new sum_i ≥ `HEDEF`, and stays set until the next start or reset.
- **`mod`, `sabit`, `tohum`:** may change mid-run; they take effect on the next load. `tohum` is used only at start.

## Timing
- **Reset values:** all outputs 0, state BOS, sums 0, LFSR 0.
- **Latency:** the first valid bus value appears on the edge that samples `basla`.
- **Bus behaviour:**
  - `avlanan_balik` is registered.
  - It is 0 whenever `gecerli` = 0.
  - In BITTI it is 0 from the first BITTI cycle.
- **Run length:** a run with all penguins done at load *k* has `gecerli` high for exactly *k* cycles, then `uretim_bitti` = 1 and `dongu_sayisi` = *k*.
- **`bitti_in` in URET:** seen high at an edge → BITTI on that edge; the bus value of the previous cycle is the last one.
- **`bitti_in` outside URET:** ignored in BOS and BITTI.
- **`reset` mid-run:** returns to BOS on the next edge, all outputs 0, overrides `basla`.
- **`basla` held high across BITTI:** restarts a new run on the first BITTI edge.

## Test plan
- **Constant 7:** mod 0, `sabit` 7, pulse `basla` → bus 15'h7FFF for 4 cycles; then bus 0, `tamam` 5'h1F, `uretim_bitti` 1, `dongu_sayisi` 4, `zaman_asimi` 0.
- **Ramp:** mod 2 → cycle 1 bus fields 0,1,2,3,4; penguin 2 done after cycle 7, so its field is 0 in cycle 8; BITTI after 8 cycles, `dongu_sayisi` 8.
- **LFSR:** mod 1, `tohum` 16'h0007 → cycle 1 fields 7,0,0,0,0; cycle 2 fields 3,0,0,2,3. With `tohum` 0, cycle 1 bus = 16'hACE1[14:0] = 15'h2CE1.
- **Timeout:** mod 0, `sabit` 0 → `gecerli` high 100 cycles; then `zaman_asimi` 1, `tamam` 0, `dongu_sayisi` 100.
- **Early stop:** mod 0, `sabit` 1, raise `bitti_in` during cycle 3 → BITTI on the next edge, `dongu_sayisi` 3, bus 0, `zaman_asimi` 0.
- **Reset mid-run:** `reset` in cycle 2 → next cycle all outputs 0. Then `basla` with mod 0, `sabit` 7 → full 4-cycle run as in the constant-7 test.

Source files
------------

// File: rtl/balik_uretici.sv
// balik_uretici
// Stimulus generator for the penguenler hunt-statistics block. It drives a
// packed per-cycle catch bus for five penguins and keeps a running total for
// each one. Once a penguin reaches HEDEF, its field is forced to zero.
// Generation stops when all penguins are done, when the consumer reports
// bitti_in, or when the cycle budget ZAMAN_ASIMI runs out.
//
// Ports
//   saat           clock, rising edge
//   reset          synchronous, active-high
//   basla          start; sampled in BOS and BITTI only
//   mod            0 constant, 1 LFSR, 2 ramp, 3 same as 0
//   sabit          constant field value for mod 0
//   tohum          LFSR seed taken at start (0 -> 16'hACE1)
//   bitti_in       consumer finished
//   avlanan_balik  registered catch bus, penguin 1 in bits [2:0]
//   gecerli        high while generating
//   tamam          per-penguin done mask
//   uretim_bitti   high in BITTI
//   zaman_asimi    run ended purely by timeout
//   dongu_sayisi   generating cycles in the current run
module balik_uretici #(
   parameter int HEDEF       = 28,
   parameter int ZAMAN_ASIMI = 100
) (
   input  logic        saat,
   input  logic        reset,
   input  logic        basla,
   input  logic [1:0]  mod,
   input  logic [2:0]  sabit,
   input  logic [15:0] tohum,
   input  logic        bitti_in,
   output logic [14:0] avlanan_balik,
   output logic        gecerli,
   output logic [4:0]  tamam,
   output logic        uretim_bitti,
   output logic        zaman_asimi,
   output logic [6:0]  dongu_sayisi
);

   typedef enum logic [1:0] {BOS, URET, BITTI} durum_t;

   durum_t            durum, durum_n;
   logic [15:0]       lfsr, lfsr_n;
   logic [4:0][6:0]   toplam, toplam_n;
   logic [4:0][2:0]   alan;
   logic [4:0]        maske, tamam_n;
   logic [6:0]        sayac_n;
   logic              baslat, yukle, bitir, sadece_zaman;

   // State transitions and per-edge actions
   always_comb begin
      durum_n      = durum;
      baslat       = 1'b0;
      yukle        = 1'b0;
      bitir        = 1'b0;
      sadece_zaman = 1'b0;
      case (durum)
         BOS, BITTI: begin
            if (basla) begin
               baslat  = 1'b1;
               durum_n = URET;
            end
         end
         URET: begin
            if ((&tamam) || bitti_in || (dongu_sayisi == 7'(ZAMAN_ASIMI))) begin
               bitir   = 1'b1;
               durum_n = BITTI;
               // The timeout flag is set only when the count limit is the
               // sole reason for stopping.
               sadece_zaman = !(&tamam) && !bitti_in;
            end else begin
               yukle = 1'b1;
            end
         end
         default: durum_n = BOS;
      endcase
   end

   // Values to load on a start or a continue edge. A start loads the seed
   // directly. Later loads use the stepped LFSR, so the fields always come
   // from the value that is being registered.
   always_comb begin
      logic [2:0] ham;
      ham      = '0;
      alan     = '0;
      toplam_n = '0;
      tamam_n  = '0;
      sayac_n  = baslat ? 7'd1 : dongu_sayisi + 7'd1;
      lfsr_n   = baslat ? ((tohum == 16'h0) ? 16'hACE1 : tohum)
                        : ({1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000));
      maske    = baslat ? 5'b0 : tamam;
      for (int i = 0; i < 5; i++) begin
         case (mod)
            2'd1:    ham = lfsr_n[3*i +: 3];
            2'd2:    ham = 3'(sayac_n + 7'(i) - 7'd1);
            default: ham = sabit;
         endcase
         alan[i]     = maske[i] ? 3'd0 : ham;
         toplam_n[i] = (baslat ? 7'd0 : toplam[i]) + {4'd0, alan[i]};
         tamam_n[i]  = maske[i] | (toplam_n[i] >= 7'(HEDEF));
      end
   end

   always_ff @(posedge saat) begin
      if (reset) begin
         durum         <= BOS;
         lfsr          <= '0;
         toplam        <= '0;
         tamam         <= '0;
         avlanan_balik <= '0;
         dongu_sayisi  <= '0;
         zaman_asimi   <= 1'b0;
      end else begin
         durum <= durum_n;
         if (baslat || yukle) begin
            lfsr          <= lfsr_n;
            toplam        <= toplam_n;
            tamam         <= tamam_n;
            avlanan_balik <= alan;
            dongu_sayisi  <= sayac_n;
            if (baslat) zaman_asimi <= 1'b0;
         end else if (bitir) begin
            avlanan_balik <= '0;
            zaman_asimi   <= sadece_zaman;
         end
      end
   end

   assign gecerli      = (durum == URET);
   assign uretim_bitti = (durum == BITTI);

endmodule
